// File: rtl/cpu_defs.sv
// Shared definitions for the CPU core and its memory responder: word sizes,
// opcodes, memory-control encodings and the responder state encoding.
package cpu_defs;

    localparam int WIDTH    = 32;
    localparam int ADDRSIZE = 12;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_JMP = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_HLT = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_RMD = 4'b1011;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_HALT    = 2'd3
    } resp_state_t;

endpackage

// File: rtl/resp_word_ram.sv
// Word RAM: one synchronous write port, one combinational read port and one
// registered read port. Addresses at or above DEPTH read 0 and never write.
module resp_word_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int AW    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    input  logic [AW-1:0]    rraddr,
    output logic [WIDTH-1:0] rrdata
);

    localparam int IW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rrdata_r;

    // Address range check: true when the word index lies below DEPTH.
    function automatic logic in_range(input logic [AW-1:0] a);
        return (a >> IW) == {AW{1'b0}};
    endfunction

    // Array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we && in_range(waddr)) begin
            mem_r[waddr[IW-1:0]] <= wdata;
        end
    end

    // Zero-latency read port.
    always_comb begin
        rdata = {WIDTH{1'b0}};
        if (in_range(raddr)) begin
            rdata = mem_r[raddr[IW-1:0]];
        end else begin
            rdata = {WIDTH{1'b0}};
        end
    end

    // Registered read port; returns the pre-write word on a same-edge write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rrdata_r <= {WIDTH{1'b0}};
        end else if (in_range(rraddr)) begin
            rrdata_r <= mem_r[rraddr[IW-1:0]];
        end else begin
            rrdata_r <= {WIDTH{1'b0}};
        end
    end

    assign rrdata = rrdata_r;

endmodule

// File: rtl/cpu_memory_responder.sv
// Memory-side partner of the CPU core: loads instruction/data memory, runs the
// core until a fetched HLT, then freezes it and exposes data memory for debug.
module cpu_memory_responder
    import cpu_defs::*;
#(
    parameter int         WIDTH    = cpu_defs::WIDTH,
    parameter int         ADDRSIZE = cpu_defs::ADDRSIZE,
    parameter int         IDEPTH   = 256,
    parameter int         DDEPTH   = 256,
    parameter logic [3:0] HLT_OP   = cpu_defs::OP_HLT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDRSIZE-1:0] INS_ADDR,
    output logic [WIDTH-1:0]    INS_MEM,
    input  logic [ADDRSIZE-1:0] MEM_ADDR,
    input  logic [WIDTH-1:0]    MEM_OUT,
    input  logic                MEM_CTRL,
    output logic [WIDTH-1:0]    MEM_IN,
    output logic                cpu_rst,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic                load_sel,
    input  logic [ADDRSIZE-1:0] load_addr,
    input  logic [WIDTH-1:0]    load_data,
    input  logic                load_last,
    input  logic                restart,
    output logic                halted,
    output logic [31:0]         run_cycles,
    input  logic [ADDRSIZE-1:0] dbg_addr,
    output logic [WIDTH-1:0]    dbg_data
);

    resp_state_t         state_r, state_next_s;
    logic                cpu_rst_r, load_ready_r, halted_r;
    logic [31:0]         run_cycles_r;
    logic                load_fire_s, hlt_fetch_s;
    logic                imem_we_s, dmem_we_s;
    logic [ADDRSIZE-1:0] dmem_waddr_s;
    logic [WIDTH-1:0]    dmem_wdata_s;
    logic [WIDTH-1:0]    imem_rr_unused_s;

    assign load_fire_s = load_valid && (state_r == ST_LOAD);
    assign hlt_fetch_s = (state_r == ST_RUN) && (INS_MEM[WIDTH-1:WIDTH-4] == HLT_OP);

    // Write-port steering: the load port owns LOAD, the core owns RUN.
    always_comb begin
        imem_we_s    = 1'b0;
        dmem_we_s    = 1'b0;
        dmem_waddr_s = MEM_ADDR;
        dmem_wdata_s = MEM_OUT;
        if (state_r == ST_LOAD) begin
            imem_we_s    = load_fire_s && !load_sel;
            dmem_we_s    = load_fire_s && load_sel;
            dmem_waddr_s = load_addr;
            dmem_wdata_s = load_data;
        end else if (state_r == ST_RUN) begin
            dmem_we_s    = (MEM_CTRL == MEM_WRITE);
        end else begin
            dmem_we_s    = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (load_fire_s && load_last) state_next_s = ST_RELEASE;
                else                          state_next_s = ST_LOAD;
            end
            ST_RELEASE: state_next_s = ST_RUN;
            ST_RUN: begin
                if (hlt_fetch_s) state_next_s = ST_HALT;
                else             state_next_s = ST_RUN;
            end
            ST_HALT: begin
                if (restart) state_next_s = ST_LOAD;
                else         state_next_s = ST_HALT;
            end
            default: state_next_s = ST_LOAD;
        endcase
    end

    // State and status registers; outputs decode the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_LOAD;
            cpu_rst_r    <= 1'b1;
            load_ready_r <= 1'b1;
            halted_r     <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            cpu_rst_r    <= (state_next_s != ST_RUN);
            load_ready_r <= (state_next_s == ST_LOAD);
            halted_r     <= (state_next_s == ST_HALT);
        end
    end

    // RUN-edge counter: saturates, holds through HALT, cleared by restart.
    always_ff @(posedge clk) begin
        if (!rst) begin
            run_cycles_r <= 32'd0;
        end else if (state_r == ST_RUN) begin
            if (run_cycles_r != 32'hFFFF_FFFF) run_cycles_r <= run_cycles_r + 32'd1;
        end else if ((state_r == ST_HALT) && restart) begin
            run_cycles_r <= 32'd0;
        end
    end

    resp_word_ram #(.DEPTH(IDEPTH), .WIDTH(WIDTH), .AW(ADDRSIZE)) u_imem (
        .clk    (clk),
        .rst    (rst),
        .we     (imem_we_s),
        .waddr  (load_addr),
        .wdata  (load_data),
        .raddr  (INS_ADDR),
        .rdata  (INS_MEM),
        .rraddr ({ADDRSIZE{1'b0}}),
        .rrdata (imem_rr_unused_s)
    );

    resp_word_ram #(.DEPTH(DDEPTH), .WIDTH(WIDTH), .AW(ADDRSIZE)) u_dmem (
        .clk    (clk),
        .rst    (rst),
        .we     (dmem_we_s),
        .waddr  (dmem_waddr_s),
        .wdata  (dmem_wdata_s),
        .raddr  (MEM_ADDR),
        .rdata  (MEM_IN),
        .rraddr (dbg_addr),
        .rrdata (dbg_data)
    );

    assign cpu_rst    = cpu_rst_r;
    assign load_ready = load_ready_r;
    assign halted     = halted_r;
    assign run_cycles = run_cycles_r;

endmodule
